multicycle_control_unit: RTL
============================

# multicycle_control_unit

Multicycle MIPS controller: a Moore FSM that sequences the shared multicycle datapath (single memory, single ULA, instruction register) through fetch, decode, execute, memory and writeback steps. It supports the same instruction subset as the single-cycle decoder: add, sub, and, or, nor, slt, lw, sw, beq, addi and j. A MemReady handshake lets the FSM stall on a slow memory.

## Interface
- WIDTH, 6, width of OP and Funct
- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  synchronous, active-high reset
- OP  input  WIDTH  opcode field from the instruction register
- Funct  input  WIDTH  funct field from the instruction register
- Zero  input  1  ULA zero flag
- MemReady  input  1  memory has completed the current access this cycle
- IorD  output  1  memory address select: 0 = PC, 1 = ULAOut
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  instruction register load
- PCEn  output  1  PC load enable, equal to PCWrite | (Branch & Zero)
- RegWrite  output  1  register file write
- RegDst  output  1  destination register select: 1 = rd, 0 = rt
- MemtoReg  output  1  writeback source: 1 = data register, 0 = ULAOut
- ULASrcA  output  1  ULA A input: 0 = PC, 1 = register A
- ULASrcB  output  2  ULA B input: 00 = B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2
- PCSrc  output  2  next-PC source: 00 = ULA result, 01 = ULAOut, 10 = jump target
- ULAControl  output  3  ULA operation code
- Illegal  output  1  unsupported instruction detected
- State  output  4  current state, for debug

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, HALT=12.
- Any output not listed for a state is 0.
- ULAControl codes: add 010, sub 110, and 000, or 001, nor 011, slt 111.
- FETCH: ULASrcB=01, ULAControl=010; IRWrite = PCWrite = MemReady.
  - MemReady=1 -> DECODE; otherwise stay in FETCH.
- DECODE: ULASrcB=11, ULAControl=010 (precompute the branch target). Next state by OP:
  - 100011 or 101011 -> MEMADR
  - 000000 -> EXECUTE
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - anything else -> illegal handling (see Configuration)
- R-type legality: Funct must be one of 100000, 100010, 100100, 100101, 100111, 101010; any other Funct is illegal.
- MEMADR: ULASrcA=1, ULASrcB=10, ULAControl=010. OP=100011 -> MEMRD; otherwise -> MEMWR.
- MEMRD: IorD=1. MemReady=1 -> MEMWB; otherwise stay.
- MEMWB: MemtoReg=1, RegWrite=1, RegDst=0 -> FETCH.
- MEMWR: IorD=1, MemWrite=1, held until MemReady=1 -> FETCH.
- EXECUTE: ULASrcA=1, ULASrcB=00, ULAControl from Funct -> ALUWB.
- ALUWB: RegDst=1, RegWrite=1 -> FETCH.
- BRANCH: ULASrcA=1, ULAControl=110, PCSrc=01, internal Branch=1 (so PCEn=Zero) -> FETCH.
- ADDIEX: ULASrcA=1, ULASrcB=10, ULAControl=010 -> ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0 -> FETCH.
- JUMP: PCSrc=10, PCWrite=1 -> FETCH.
- HALT: absorbing; all strobes 0, Illegal=1. Only rst leaves HALT.

## Timing
- Reset: rst sampled high -> State=FETCH on the next edge.
  - While rst is high, MemWrite, IRWrite, PCEn and RegWrite are forced to 0 and Illegal=0.
- Reset mid-operation aborts the current instruction; no partial writeback occurs after the reset edge.
- Outputs decode combinationally from State only, except:
  - IRWrite and PCEn in FETCH, which also depend on MemReady;
  - PCEn in BRANCH, which also depends on Zero.
- Cycle counts with MemReady tied to 1:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type and addi: 4 cycles
  - beq and j: 3 cycles
- Each cycle with MemReady=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- MemWrite stays asserted and IorD stays stable throughout a MEMWR stall.

## Configuration
- MCU_ILLEGAL_TRAP_EN defined:
  - an illegal OP, or R-type with an illegal Funct, in DECODE -> HALT;
  - Illegal=1 from the following cycle until reset.
- MCU_ILLEGAL_TRAP_EN undefined:
  - an illegal instruction in DECODE -> FETCH, executed as a 2-cycle no-op with no register or memory write;
  - Illegal is tied to 0.

## Test plan
- Reset then add: rst=1 for 2 cycles, OP=000000, Funct=100000, MemReady=1.
  - -> State sequence 0, 1, 6, 7, 0; ULAControl=010 in EXECUTE; RegWrite=1, RegDst=1 only in ALUWB.
- lw with stall: OP=100011, MemReady=0 for 3 cycles in MEMRD.
  - -> State sequence 0, 1, 2, 3, 3, 3, 3, 4, 0; IorD=1 throughout MEMRD; MemtoReg=1, RegWrite=1 in MEMWB.
- beq: OP=000100.
  - Zero=1 -> PCEn=1, PCSrc=01 in BRANCH.
  - Zero=0 -> PCEn=0.
  - Both cases return to FETCH after 3 cycles.
- sw then j: OP=101011 with MemReady=0 for 1 cycle in MEMWR, then OP=000010.
  - -> MemWrite=1 for 2 cycles; then JUMP with PCSrc=10, PCEn=1.
- Illegal instruction: OP=111111.
  - With MCU_ILLEGAL_TRAP_EN: State=12 and Illegal=1 held for 10 cycles; rst -> State=0, Illegal=0.
  - Without: return to FETCH with no strobes asserted.
- Reset mid-MEMWR: rst asserted while State=5 and MemReady=0.
  - -> MemWrite=0 in the same cycle; State=0 on the next edge.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
// Moore FSM sequencing a shared multicycle MIPS datapath (single memory,
// single ULA, instruction register) through fetch, decode, execute, memory
// and writeback steps for add, sub, and, or, nor, slt, lw, sw, beq, addi, j.
// MemReady stalls FETCH, MEMRD and MEMWR on a slow memory.
//
// Optional feature macro: MCU_ILLEGAL_TRAP_EN
//   defined   : an unsupported instruction traps into HALT and raises Illegal
//               until reset.
//   undefined : an unsupported instruction is dropped as a no-op and Illegal
//               is tied to 0.

module multicycle_control_unit #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] OP,
  input  logic [WIDTH-1:0] Funct,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             IorD,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCEn,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             ULASrcA,
  output logic [1:0]       ULASrcB,
  output logic [1:0]       PCSrc,
  output logic [2:0]       ULAControl,
  output logic             Illegal,
  output logic [3:0]       State
);

  // Controller states; the encoding is visible on the State debug port.
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_HALT    = 4'd12
  } state_t;

  // ULA operation codes.
  typedef enum logic [2:0] {
    ULA_AND = 3'b000,
    ULA_OR  = 3'b001,
    ULA_ADD = 3'b010,
    ULA_NOR = 3'b011,
    ULA_SUB = 3'b110,
    ULA_SLT = 3'b111
  } ula_op_t;

  // ULA B operand selects.
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // Next-PC selects.
  localparam logic [1:0] PCSRC_ULA  = 2'b00;
  localparam logic [1:0] PCSRC_OUT  = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;

  // Supported opcodes.
  localparam logic [WIDTH-1:0] OP_RTYPE = WIDTH'(6'b000000);
  localparam logic [WIDTH-1:0] OP_J     = WIDTH'(6'b000010);
  localparam logic [WIDTH-1:0] OP_BEQ   = WIDTH'(6'b000100);
  localparam logic [WIDTH-1:0] OP_ADDI  = WIDTH'(6'b001000);
  localparam logic [WIDTH-1:0] OP_LW    = WIDTH'(6'b100011);
  localparam logic [WIDTH-1:0] OP_SW    = WIDTH'(6'b101011);

  // Supported R-type funct codes.
  localparam logic [WIDTH-1:0] FN_ADD = WIDTH'(6'b100000);
  localparam logic [WIDTH-1:0] FN_SUB = WIDTH'(6'b100010);
  localparam logic [WIDTH-1:0] FN_AND = WIDTH'(6'b100100);
  localparam logic [WIDTH-1:0] FN_OR  = WIDTH'(6'b100101);
  localparam logic [WIDTH-1:0] FN_NOR = WIDTH'(6'b100111);
  localparam logic [WIDTH-1:0] FN_SLT = WIDTH'(6'b101010);

  // Where an unsupported instruction goes after DECODE.
`ifdef MCU_ILLEGAL_TRAP_EN
  localparam state_t ILLEGAL_NEXT = S_HALT;
`else
  localparam state_t ILLEGAL_NEXT = S_FETCH;
`endif

  state_t  state_q, state_d;

  // Raw (pre-reset-mask) control signals produced by the FSM decode.
  logic    mem_write, ir_write, reg_write, pc_write, branch;
  logic    iord, reg_dst, mem_to_reg, src_a;
  logic [1:0] src_b, pc_src;
  ula_op_t ula_ctl;
`ifdef MCU_ILLEGAL_TRAP_EN
  logic    illegal_raw;
`endif

  // Funct decode for R-type: ULA operation and legality.
  logic    funct_ok;
  ula_op_t rtype_ctl;

  // Map the funct field to a ULA operation and flag unsupported codes.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    funct_ok  = 1'b1;
    rtype_ctl = ULA_ADD;
    case (Funct)
      FN_ADD:  rtype_ctl = ULA_ADD;
      FN_SUB:  rtype_ctl = ULA_SUB;
      FN_AND:  rtype_ctl = ULA_AND;
      FN_OR:   rtype_ctl = ULA_OR;
      FN_NOR:  rtype_ctl = ULA_NOR;
      FN_SLT:  rtype_ctl = ULA_SLT;
      default: funct_ok  = 1'b0;
    endcase
  end

  // State register; reset is synchronous and always returns to FETCH.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // values from before the edge, independent of block ordering.
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic and per-state control decode (Moore, except the
  // MemReady-gated fetch strobes and the Zero-gated branch).
  always_comb begin
    state_d    = state_q;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    src_a      = 1'b0;
    src_b      = SRCB_REG;
    pc_src     = PCSRC_ULA;
    ula_ctl    = ULA_AND;
`ifdef MCU_ILLEGAL_TRAP_EN
    illegal_raw = 1'b0;
`endif

    case (state_q)
      S_FETCH: begin
        // PC+4 is computed every cycle; only commit once memory delivers.
        src_b    = SRCB_FOUR;
        ula_ctl  = ULA_ADD;
        ir_write = MemReady;
        pc_write = MemReady;
        if (MemReady) state_d = S_DECODE;
      end

      S_DECODE: begin
        // Precompute the branch target while the opcode is decoded.
        src_b   = SRCB_IMMSH;
        ula_ctl = ULA_ADD;
        case (OP)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = funct_ok ? S_EXECUTE : ILLEGAL_NEXT;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = ILLEGAL_NEXT;
        endcase
      end

      S_MEMADR: begin
        src_a   = 1'b1;
        src_b   = SRCB_IMM;
        ula_ctl = ULA_ADD;
        state_d = (OP == OP_LW) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        iord = 1'b1;
        if (MemReady) state_d = S_MEMWB;
      end

      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEMWR: begin
        // Strobe and address are held steady for the whole stall.
        iord      = 1'b1;
        mem_write = 1'b1;
        if (MemReady) state_d = S_FETCH;
      end

      S_EXECUTE: begin
        src_a   = 1'b1;
        src_b   = SRCB_REG;
        ula_ctl = rtype_ctl;
        state_d = S_ALUWB;
      end

      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end

      S_BRANCH: begin
        src_a   = 1'b1;
        ula_ctl = ULA_SUB;
        pc_src  = PCSRC_OUT;
        branch  = 1'b1;
        state_d = S_FETCH;
      end

      S_ADDIEX: begin
        src_a   = 1'b1;
        src_b   = SRCB_IMM;
        ula_ctl = ULA_ADD;
        state_d = S_ADDIWB;
      end

      S_ADDIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end

      S_JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
        state_d  = S_FETCH;
      end

      S_HALT: begin
        // Absorbing trap; only reset leaves it.
`ifdef MCU_ILLEGAL_TRAP_EN
        illegal_raw = 1'b1;
`endif
        state_d = S_HALT;
      end

      default: begin
        // Unused encodings recover to a clean fetch.
        state_d = S_FETCH;
      end
    endcase
  end

  // Side-effecting strobes are suppressed while reset is held so an aborted
  // instruction can never write the register file, memory or PC.
  assign MemWrite   = mem_write & ~rst;
  assign IRWrite    = ir_write  & ~rst;
  assign RegWrite   = reg_write & ~rst;
  assign PCEn       = (pc_write | (branch & Zero)) & ~rst;

  assign IorD       = iord;
  assign RegDst     = reg_dst;
  assign MemtoReg   = mem_to_reg;
  assign ULASrcA    = src_a;
  assign ULASrcB    = src_b;
  assign PCSrc      = pc_src;
  assign ULAControl = ula_ctl;
  assign State      = state_q;

`ifdef MCU_ILLEGAL_TRAP_EN
  assign Illegal = illegal_raw & ~rst;
`else
  assign Illegal = 1'b0;
`endif

endmodule
